// File: rtl/wrr_arb_pkg.sv
// Shared types and constants for the weighted round-robin merge arbiter.
//   wrr_state_t : which source currently holds the grant
//   SRC_A/SRC_B : source tag values carried in down_data[0]
//   STAT_W      : width of the optional grant counters
package wrr_arb_pkg;

  typedef enum logic {GNT_A, GNT_B} wrr_state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int STAT_W = 16;

endpackage

// File: rtl/wrr_out_reg.sv
// Registered output stage of the merge arbiter: one word of storage with
// valid/ready handshake.
//   clk, rst  : clock, synchronous active-high reset
//   xfer_i    : a word is being accepted from upstream this cycle
//   data_i    : word to capture on xfer_i
//   ready_i   : downstream consumer accepts the held word
//   valid_o   : held word is valid
//   data_o    : held word
//   load_o    : register can take a new word this cycle
module wrr_out_reg #(
  parameter int D_WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               xfer_i,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [D_WIDTH-1:0] data_o,
  output logic               load_o
);

  logic               valid_q, valid_d;
  logic [D_WIDTH-1:0] data_q, data_d;

  assign load_o  = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (xfer_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/wrr_merge_arbiter.sv
// Two-input weighted round-robin arbiter merging valid/ready streams A and B
// into one registered downstream stream. down_data[0] carries the source tag
// (A=0, B=1). Work-conserving: an idle granted source never blocks the other.
//   clk, rst                           : clock, synchronous active-high reset
//   up_valid_a/up_ready_a/up_data_a    : source A stream (data bit 0 ignored)
//   up_valid_b/up_ready_b/up_data_b    : source B stream (data bit 0 ignored)
//   down_valid/down_ready/down_data    : merged, registered output stream
//   grant_cnt_a/grant_cnt_b            : saturating transfer counters, present
//                                        only when WRR_ARB_STATS_EN is defined
module wrr_merge_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int D_WIDTH  = 6,
  parameter int W_WIDTH  = 2,
  parameter int WEIGHT_A = 2,
  parameter int WEIGHT_B = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid_a,
  output logic               up_ready_a,
  input  logic [D_WIDTH-1:0] up_data_a,
  input  logic               up_valid_b,
  output logic               up_ready_b,
  input  logic [D_WIDTH-1:0] up_data_b,
  output logic               down_valid,
  input  logic               down_ready,
  output logic [D_WIDTH-1:0] down_data
`ifdef WRR_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]  grant_cnt_a,
  output logic [STAT_W-1:0]  grant_cnt_b
`endif
);

  if (WEIGHT_A < 1 || WEIGHT_A > (2 ** W_WIDTH) - 1) begin : g_bad_weight_a
    $error("WEIGHT_A out of range 1..2**W_WIDTH-1");
  end
  if (WEIGHT_B < 1 || WEIGHT_B > (2 ** W_WIDTH) - 1) begin : g_bad_weight_b
    $error("WEIGHT_B out of range 1..2**W_WIDTH-1");
  end

  localparam logic [W_WIDTH-1:0] WeightA = W_WIDTH'(WEIGHT_A);
  localparam logic [W_WIDTH-1:0] WeightB = W_WIDTH'(WEIGHT_B);

  wrr_state_t         state_q, state_d;
  logic [W_WIDTH-1:0] credit_q, credit_d;
  logic [W_WIDTH-1:0] eff;
  logic               state_src, sel, v_state, v_other;
  logic               load, xfer;
  logic [D_WIDTH-1:0] sel_data;

  // Source select: granted source if valid, else the other if valid.
  always_comb begin
    state_src = (state_q == GNT_B) ? SRC_B : SRC_A;
    v_state   = (state_src == SRC_B) ? up_valid_b : up_valid_a;
    v_other   = (state_src == SRC_B) ? up_valid_a : up_valid_b;
    sel       = state_src;
    if (!v_state && v_other) begin
      sel = ~state_src;
    end
  end

  assign up_ready_a = ~rst & load & (sel == SRC_A);
  assign up_ready_b = ~rst & load & (sel == SRC_B);
  assign xfer = (sel == SRC_A) ? (up_valid_a & up_ready_a) : (up_valid_b & up_ready_b);
  assign sel_data = {(sel == SRC_B) ? up_data_b[D_WIDTH-1:1] : up_data_a[D_WIDTH-1:1], sel};

  // A switch caused by idleness starts the new source with its full weight.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    eff      = (sel == state_src) ? credit_q : ((sel == SRC_B) ? WeightB : WeightA);
    if (xfer) begin
      if (eff == W_WIDTH'(1)) begin
        state_d  = (sel == SRC_B) ? GNT_A : GNT_B;
        credit_d = (sel == SRC_B) ? WeightA : WeightB;
      end else begin
        state_d  = (sel == SRC_B) ? GNT_B : GNT_A;
        credit_d = eff - W_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GNT_A;
      credit_q <= WeightA;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

  wrr_out_reg #(
    .D_WIDTH(D_WIDTH)
  ) u_out_reg (
    .clk    (clk),
    .rst    (rst),
    .xfer_i (xfer),
    .data_i (sel_data),
    .ready_i(down_ready),
    .valid_o(down_valid),
    .data_o (down_data),
    .load_o (load)
  );

`ifdef WRR_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt_a_q, grant_cnt_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_a_q <= '0;
      grant_cnt_b_q <= '0;
    end else if (xfer) begin
      if (sel == SRC_A && grant_cnt_a_q != '1) grant_cnt_a_q <= grant_cnt_a_q + 1'b1;
      if (sel == SRC_B && grant_cnt_b_q != '1) grant_cnt_b_q <= grant_cnt_b_q + 1'b1;
    end
  end

  assign grant_cnt_a = grant_cnt_a_q;
  assign grant_cnt_b = grant_cnt_b_q;
`endif

endmodule
